// File: rtl/wb_pkg.sv
// wb_pkg: shared load funct3 encodings and write-back FSM state encoding
package wb_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;
  typedef enum logic {WB_IDLE, WB_WAIT_MEM} wb_state_e;
endpackage

// File: rtl/wb_stage_ctrl_align.sv
// load_align: shift load data into the low lanes, size it, extend it, and flag illegal or misaligned loads
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [OFF_W-1:0] addr_lo,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  data,
  output logic             err
);
  logic [XLEN-1:0] shifted, left;
  logic [7:0] kill;
  logic illegal, misaligned;
  // Push the access into the top of the word, then shift back down logically or arithmetically to extend
  always_comb begin
    shifted = mem_rdata >> {addr_lo, 3'b000};
    kill = 8'(XLEN) - (8'd8 << funct3[1:0]);
    left = shifted << kill;
    data = funct3[2] ? left >> kill : XLEN'($signed(left) >>> kill);
    illegal = (funct3 == F3_BAD) || (XLEN == 32 && (funct3 == F3_LD || funct3 == F3_LWU));
    misaligned = |(addr_lo & OFF_W'((4'd1 << funct3[1:0]) - 4'd1));
    err = illegal | misaligned;
  end
endmodule

// File: rtl/wb_stage_ctrl.sv
// wb_stage_ctrl: write-back stage with late-load wait, register-file write port and forwarding tap
module wb_stage_ctrl
  import wb_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW = 5,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_we,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_is_load,
  input  logic [2:0]       in_funct3,
  input  logic [OFF_W-1:0] in_addr_lo,
  input  logic [XLEN-1:0]  in_result,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic [AW-1:0]    fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             load_err,
  output logic             busy
);
  wb_state_e state_q, state_d;
  logic p_we_q, p_we_d;
  logic [AW-1:0] p_rd_q, p_rd_d;
  logic [2:0] p_f3_q, p_f3_d;
  logic [OFF_W-1:0] p_off_q, p_off_d;
  logic rf_we_q, rf_we_d, load_err_q, load_err_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic waiting, wr, wr_we, wr_err;
  logic [AW-1:0] wr_rd;
  logic [XLEN-1:0] wr_data, al_data;
  logic [2:0] al_f3;
  logic [OFF_W-1:0] al_off;
  logic al_err;
  assign waiting = state_q == WB_WAIT_MEM;
  assign al_f3 = waiting ? p_f3_q : in_funct3;
  assign al_off = waiting ? p_off_q : in_addr_lo;
  load_align #(.XLEN(XLEN)) u_align (
    .mem_rdata(mem_rdata),
    .addr_lo  (al_off),
    .funct3   (al_f3),
    .data     (al_data),
    .err      (al_err)
  );
  // Next state, pending-load capture and the single-cycle write / error pulse
  always_comb begin
    state_d = state_q;
    p_we_d = p_we_q;
    p_rd_d = p_rd_q;
    p_f3_d = p_f3_q;
    p_off_d = p_off_q;
    rf_we_d = 1'b0;
    load_err_d = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wr = 1'b0;
    wr_we = in_we;
    wr_rd = in_rd;
    wr_data = in_result;
    wr_err = 1'b0;
    if (waiting) begin
      wr_we = p_we_q;
      wr_rd = p_rd_q;
      wr_data = al_data;
      wr_err = al_err;
      wr = mem_rvalid;
      state_d = mem_rvalid ? WB_IDLE : WB_WAIT_MEM;
    end else if (in_valid) begin
      if (!in_is_load) begin
        wr = 1'b1;
      end else if (mem_rvalid) begin
        wr = 1'b1;
        wr_data = al_data;
        wr_err = al_err;
      end else begin
        p_we_d = in_we;
        p_rd_d = in_rd;
        p_f3_d = in_funct3;
        p_off_d = in_addr_lo;
        state_d = WB_WAIT_MEM;
      end
    end
    if (wr) begin
      rf_we_d = wr_we & (|wr_rd) & ~wr_err;
      load_err_d = wr_err;
      rf_waddr_d = rf_we_d ? wr_rd : rf_waddr_q;
      rf_wdata_d = rf_we_d ? wr_data : rf_wdata_q;
    end
  end
  // State, pending-load and output registers; reset drops any pending load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_IDLE;
      p_we_q <= 1'b0;
      p_rd_q <= '0;
      p_f3_q <= '0;
      p_off_q <= '0;
      rf_we_q <= 1'b0;
      load_err_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      p_we_q <= p_we_d;
      p_rd_q <= p_rd_d;
      p_f3_q <= p_f3_d;
      p_off_q <= p_off_d;
      rf_we_q <= rf_we_d;
      load_err_q <= load_err_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end
  assign in_ready = ~waiting;
  assign busy = waiting;
  assign rf_we = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign load_err = load_err_q;
  assign fwd_valid = rf_we_q;
  assign fwd_rd = rf_waddr_q;
  assign fwd_data = rf_wdata_q;
endmodule

// File: tb/tb_wb_stage_ctrl.sv
// tb_wb_stage_ctrl: directed checks of the write-back stage (64-bit and 32-bit builds)
module tb_wb_stage_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 0, in_we = 0, in_is_load = 0, mem_rvalid = 0;
  logic [4:0] in_rd = 0;
  logic [2:0] in_funct3 = 0;
  logic [2:0] in_addr_lo = 0;
  logic [63:0] in_result = 0, mem_rdata = 0;
  logic in_ready, rf_we, fwd_valid, load_err, busy;
  logic [4:0] rf_waddr, fwd_rd;
  logic [63:0] rf_wdata, fwd_data;
  logic r32_ready, r32_we, r32_fv, r32_err, r32_busy;
  logic [4:0] r32_waddr, r32_frd;
  logic [31:0] r32_wdata, r32_fdata;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  wb_stage_ctrl #(.XLEN(64), .AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
    .in_rd(in_rd), .in_is_load(in_is_load), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_result(in_result), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .load_err(load_err), .busy(busy)
  );
  wb_stage_ctrl #(.XLEN(32), .AW(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32_ready), .in_we(in_we),
    .in_rd(in_rd), .in_is_load(in_is_load), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo[1:0]),
    .in_result(in_result[31:0]), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
    .rf_we(r32_we), .rf_waddr(r32_waddr), .rf_wdata(r32_wdata), .fwd_valid(r32_fv),
    .fwd_rd(r32_frd), .fwd_data(r32_fdata), .load_err(r32_err), .busy(r32_busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic ld,
                       input logic [2:0] f3, input logic [2:0] off, input logic [63:0] res,
                       input logic rv, input logic [63:0] rdat);
    in_valid = v; in_we = we; in_rd = rd; in_is_load = ld; in_funct3 = f3;
    in_addr_lo = off; in_result = res; mem_rvalid = rv; mem_rdata = rdat;
  endtask
  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [63:0] d, input logic e);
    chk({tag, ".we"}, 64'(rf_we), 64'(we));
    chk({tag, ".waddr"}, 64'(rf_waddr), 64'(a));
    chk({tag, ".wdata"}, rf_wdata, d);
    chk({tag, ".err"}, 64'(load_err), 64'(e));
  endtask
  initial begin
    #2;
    chk("rst.we", 64'(rf_we), 0);
    chk("rst.waddr", 64'(rf_waddr), 0);
    chk("rst.wdata", rf_wdata, 0);
    chk("rst.err", 64'(load_err), 0);
    chk("rst.busy", 64'(busy), 0);
    chk("rst.ready", 64'(in_ready), 1);
    step();
    rst = 1'b0;
    // ALU write, latency 1, forwarding tap mirrors the write port
    drive(1, 1, 5, 0, 3'b111, 3, 64'd20, 0, 0);
    step();
    chk_wr("alu", 1, 5, 64'd20, 0);
    chk("alu.fv", 64'(fwd_valid), 1);
    chk("alu.frd", 64'(fwd_rd), 5);
    chk("alu.fdata", fwd_data, 64'd20);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_wr("alu.idle", 0, 5, 64'd20, 0);
    // Same-cycle loads
    drive(1, 1, 6, 1, 3'b000, 0, 0, 1, 64'h0000_0000_0000_0080);
    step();
    chk_wr("lb", 1, 6, 64'hFFFF_FFFF_FFFF_FF80, 0);
    drive(1, 1, 7, 1, 3'b100, 0, 0, 1, 64'h0000_0000_0000_0080);
    step();
    chk_wr("lbu", 1, 7, 64'h80, 0);
    drive(1, 1, 8, 1, 3'b001, 2, 0, 1, 64'h0000_0000_ABCD_0000);
    step();
    chk_wr("lh2", 1, 8, 64'hFFFF_FFFF_FFFF_ABCD, 0);
    drive(1, 1, 9, 1, 3'b101, 2, 0, 1, 64'h0000_0000_ABCD_0000);
    step();
    chk_wr("lhu2", 1, 9, 64'h0000_0000_0000_ABCD, 0);
    drive(1, 1, 9, 1, 3'b110, 4, 0, 1, 64'hF234_5678_0000_0000);
    step();
    chk_wr("lwu4", 1, 9, 64'h0000_0000_F234_5678, 0);
    // Late load: LW at offset 4, data three cycles after acceptance
    drive(1, 1, 8, 1, 3'b010, 4, 0, 0, 0);
    step();
    chk("late.busy0", 64'(busy), 1);
    chk("late.ready0", 64'(in_ready), 0);
    chk("late.we0", 64'(rf_we), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("late.busy1", 64'(busy), 1);
    step();
    chk("late.ready2", 64'(in_ready), 0);
    mem_rvalid = 1; mem_rdata = 64'h8000_0000_0000_0000;
    step();
    chk_wr("late", 1, 8, 64'hFFFF_FFFF_8000_0000, 0);
    chk("late.busy", 64'(busy), 0);
    chk("late.ready", 64'(in_ready), 1);
    mem_rvalid = 0;
    step();
    chk("late.pulse", 64'(rf_we), 0);
    // Error cases
    drive(1, 1, 10, 1, 3'b001, 1, 0, 1, 64'h1234);
    step();
    chk_wr("lh.mis", 0, 8, 64'hFFFF_FFFF_8000_0000, 1);
    drive(1, 1, 10, 1, 3'b111, 0, 0, 1, 64'h1234);
    step();
    chk_wr("f3.111", 0, 8, 64'hFFFF_FFFF_8000_0000, 1);
    drive(1, 1, 10, 1, 3'b011, 4, 0, 1, 64'h1234);
    step();
    chk_wr("ld.mis", 0, 8, 64'hFFFF_FFFF_8000_0000, 1);
    drive(1, 1, 0, 0, 0, 0, 64'd99, 0, 0);
    step();
    chk_wr("rd0", 0, 8, 64'hFFFF_FFFF_8000_0000, 0);
    drive(1, 0, 12, 0, 3'b111, 1, 64'd77, 0, 0);
    step();
    chk_wr("we0", 0, 8, 64'hFFFF_FFFF_8000_0000, 0);
    // Back-to-back ALU writes
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 5'(i), 0, 0, 0, 64'(100 + i), 0, 0);
      step();
      chk_wr($sformatf("b2b%0d", i), 1, 5'(i), 64'(100 + i), 0);
      chk($sformatf("b2b%0d.ready", i), 64'(in_ready), 1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("b2b.end", 64'(rf_we), 0);
    // Reset during WAIT_MEM drops the load
    drive(1, 1, 11, 1, 3'b010, 0, 0, 0, 0);
    step();
    chk("rw.busy", 64'(busy), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    #2;
    chk("rw.rbusy", 64'(busy), 0);
    chk("rw.rwdata", rf_wdata, 0);
    step();
    rst = 0;
    mem_rvalid = 1; mem_rdata = 64'h5555;
    step();
    chk_wr("rw.after", 0, 0, 0, 0);
    chk("rw.ready", 64'(in_ready), 1);
    chk("rw.busy2", 64'(busy), 0);
    mem_rvalid = 0;
    step();
    // LD: legal at XLEN=64, illegal at XLEN=32
    drive(1, 1, 9, 1, 3'b011, 0, 0, 1, 64'h8123_4567_89AB_CDEF);
    step();
    chk_wr("ld64", 1, 9, 64'h8123_4567_89AB_CDEF, 0);
    chk("ld32.err", 64'(r32_err), 1);
    chk("ld32.we", 64'(r32_we), 0);
    drive(1, 1, 9, 1, 3'b010, 0, 0, 1, 64'h0000_0000_89AB_CDEF);
    step();
    chk("lw32.err", 64'(r32_err), 0);
    chk("lw32.wdata", 64'(r32_wdata), 64'h89AB_CDEF);
    chk("lw32.fdata", 64'(r32_fdata), 64'h89AB_CDEF);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
